// File: rtl/wallace_product_accumulator.sv
// Frame accumulator for 64-bit multiplier products; sums up to N products per frame.
// Optional build macro ACC_SATURATE_EN: clamp the accumulator at all-ones and flag out_ovf.
module wallace_product_accumulator #(
   parameter int unsigned PROD_W = 64,
   parameter int unsigned ACC_W  = 72,
   parameter int unsigned N      = 8,
   parameter int unsigned CNT_W  = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [PROD_W-1:0] in_prod,
   input  logic              in_last,
   input  logic              acc_clear,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [ACC_W-1:0]  out_sum,
   output logic [CNT_W-1:0]  out_count,
   output logic              out_ovf
);

   generate
      if (ACC_W < PROD_W) begin : g_bad_acc_w
         $error("ACC_W must be at least PROD_W");
      end
      if (N < 1) begin : g_bad_n
         $error("N must be at least 1");
      end
      if (N >= (64'd1 << CNT_W)) begin : g_bad_cnt_w
         $error("CNT_W too narrow for N");
      end
   endgenerate

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);

   typedef enum logic {
      ST_ACC  = 1'b0,
      ST_DONE = 1'b1
   } state_e;

   state_e              state_q,     state_d;
   logic [ACC_W-1:0]    acc_q,       acc_d;
   logic [CNT_W-1:0]    cnt_q,       cnt_d;
   logic                ovf_q,       ovf_d;
   logic                in_ready_q,  in_ready_d;
   logic                out_valid_q, out_valid_d;
   logic [ACC_W-1:0]    out_sum_q,   out_sum_d;
   logic [CNT_W-1:0]    out_count_q, out_count_d;
   logic                out_ovf_q,   out_ovf_d;

   logic [ACC_W-1:0]    acc_add_c;
   logic                sat_c;
   logic [CNT_W-1:0]    cnt_inc_c;
   logic                frame_end_c;

   // Accumulator adder: saturating or wrapping depending on build
`ifdef ACC_SATURATE_EN
   logic [ACC_W:0] sum_ext_c;
   always_comb begin
      sum_ext_c = (ACC_W+1)'(acc_q) + (ACC_W+1)'(in_prod);
      sat_c     = sum_ext_c[ACC_W];
      acc_add_c = sat_c ? {ACC_W{1'b1}} : sum_ext_c[ACC_W-1:0];
   end
`else
   always_comb begin
      sat_c     = 1'b0;
      acc_add_c = acc_q + ACC_W'(in_prod);
   end
`endif

   assign cnt_inc_c   = cnt_q + CNT_W'(1);
   assign frame_end_c = in_last || (cnt_q == CNT_LAST);

   // Next-state and registered-output logic; acc_clear outranks handshakes
   always_comb begin
      state_d     = state_q;
      acc_d       = acc_q;
      cnt_d       = cnt_q;
      ovf_d       = ovf_q;
      out_sum_d   = out_sum_q;
      out_count_d = out_count_q;
      out_ovf_d   = out_ovf_q;

      if (acc_clear) begin
         state_d   = ST_ACC;
         acc_d     = '0;
         cnt_d     = '0;
         ovf_d     = 1'b0;
         out_ovf_d = 1'b0;
      end else begin
         unique case (state_q)
            ST_ACC: begin
               if (in_valid) begin
                  acc_d = acc_add_c;
                  cnt_d = cnt_inc_c;
                  ovf_d = ovf_q | sat_c;
                  if (frame_end_c) begin
                     state_d     = ST_DONE;
                     out_sum_d   = acc_add_c;
                     out_count_d = cnt_inc_c;
                     out_ovf_d   = ovf_q | sat_c;
                  end
               end
            end
            ST_DONE: begin
               if (out_ready) begin
                  state_d = ST_ACC;
                  acc_d   = '0;
                  cnt_d   = '0;
                  ovf_d   = 1'b0;
               end
            end
            default: state_d = ST_ACC;
         endcase
      end

      in_ready_d  = (state_d == ST_ACC);
      out_valid_d = (state_d == ST_DONE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_ACC;
         acc_q       <= '0;
         cnt_q       <= '0;
         ovf_q       <= 1'b0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         out_sum_q   <= '0;
         out_count_q <= '0;
         out_ovf_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         acc_q       <= acc_d;
         cnt_q       <= cnt_d;
         ovf_q       <= ovf_d;
         in_ready_q  <= in_ready_d;
         out_valid_q <= out_valid_d;
         out_sum_q   <= out_sum_d;
         out_count_q <= out_count_d;
         out_ovf_q   <= out_ovf_d;
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign out_sum   = out_sum_q;
   assign out_count = out_count_q;
   assign out_ovf   = out_ovf_q;

endmodule

// File: tb/tb_wallace_product_accumulator.sv
// Bench for wallace_product_accumulator (ACC_W=66 so wrap/saturation is reachable).
module tb_wallace_product_accumulator;

   localparam int unsigned PROD_W = 64;
   localparam int unsigned ACC_W  = 66;
   localparam int unsigned N      = 8;
   localparam int unsigned CNT_W  = 4;
   localparam logic [79:0] MAXV   = (80'd1 << ACC_W) - 80'd1;
   localparam logic [63:0] ONES   = 64'hFFFF_FFFF_FFFF_FFFF;

   logic              clk = 1'b0;
   logic              rst;
   logic              in_valid;
   logic              in_ready;
   logic [PROD_W-1:0] in_prod;
   logic              in_last;
   logic              acc_clear;
   logic              out_valid;
   logic              out_ready;
   logic [ACC_W-1:0]  out_sum;
   logic [CNT_W-1:0]  out_count;
   logic              out_ovf;

   int tests = 0;
   int fails = 0;

   wallace_product_accumulator #(
      .PROD_W(PROD_W), .ACC_W(ACC_W), .N(N), .CNT_W(CNT_W)
   ) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready), .in_prod(in_prod), .in_last(in_last),
      .acc_clear(acc_clear),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_sum(out_sum), .out_count(out_count), .out_ovf(out_ovf)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Reference: frame result from the exact (unbounded) sum of its products
   function automatic void model(input logic [79:0] t, output logic [ACC_W-1:0] s,
                                 output logic o);
`ifdef ACC_SATURATE_EN
      if (t > MAXV) begin
         s = {ACC_W{1'b1}};
         o = 1'b1;
      end else begin
         s = t[ACC_W-1:0];
         o = 1'b0;
      end
`else
      s = t[ACC_W-1:0];
      o = 1'b0;
`endif
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [63:0] p, input logic l, output bit ok);
      int k;
      k        = 0;
      in_valid = 1'b1;
      in_prod  = p;
      in_last  = l;
      while (!in_ready && k < 50) begin
         tick();
         k++;
      end
      ok = in_ready;
      tick();
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   task automatic wait_out(output bit ok);
      int k;
      k = 0;
      while (!out_valid && k < 50) begin
         tick();
         k++;
      end
      ok = out_valid;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      tests++;
      if ({in_ready, out_valid, out_ovf} !== 3'b100) begin
         fails++;
         $display("FAIL reset_flags: got rdy/vld/ovf=%b expected 100", {in_ready, out_valid, out_ovf});
      end
      tests++;
      if (out_sum !== '0 || out_count !== '0) begin
         fails++;
         $display("FAIL reset_data: got sum=%0h cnt=%0d expected 0/0", out_sum, out_count);
      end
   endtask

   task automatic test_full_frame();
      logic [ACC_W-1:0] es;
      logic             eo;
      model(80'd36, es, eo);
      out_ready = 1'b1;
      for (int i = 1; i <= 8; i++) begin
         in_valid = 1'b1;
         in_prod  = 64'(i);
         in_last  = 1'b0;
         tick();
         if (i < 8) begin
            tests++;
            if ({in_ready, out_valid} !== 2'b10) begin
               fails++;
               $display("FAIL full_mid%0d: got rdy/vld=%b expected 10", i, {in_ready, out_valid});
            end
         end else begin
            tests++;
            if ({in_ready, out_valid} !== 2'b01 || out_sum !== es || out_count !== CNT_W'(8)) begin
               fails++;
               $display("FAIL full_out: got rdy/vld=%b sum=%0d cnt=%0d expected 01/%0d/8",
                        {in_ready, out_valid}, out_sum, out_count, es);
            end
         end
      end
      in_valid = 1'b0;
      tick();
      tests++;
      if ({in_ready, out_valid} !== 2'b10) begin
         fails++;
         $display("FAIL full_after: got rdy/vld=%b expected 10", {in_ready, out_valid});
      end
   endtask

   task automatic test_carry();
      bit ok;
      logic [ACC_W-1:0] es;
      logic             eo;
      model(80'(ONES) + 80'd1, es, eo);
      out_ready = 1'b1;
      push(ONES, 1'b0, ok);
      push(64'd1, 1'b1, ok);
      tests++;
      if (!ok || out_valid !== 1'b1 || out_sum !== es || out_count !== CNT_W'(2) || out_ovf !== 1'b0) begin
         fails++;
         $display("FAIL carry: got vld=%b sum=%0h cnt=%0d ovf=%b expected 1/%0h/2/0",
                  out_valid, out_sum, out_count, out_ovf, es);
      end
      tick();
   endtask

   task automatic test_backpressure();
      bit ok;
      out_ready = 1'b0;
      push(64'd10, 1'b0, ok);
      push(64'd20, 1'b0, ok);
      push(64'd30, 1'b1, ok);
      for (int i = 0; i < 5; i++) begin
         in_valid = 1'b1;
         in_prod  = 64'd99;
         in_last  = 1'b1;
         tick();
         tests++;
         if ({in_ready, out_valid} !== 2'b01 || out_sum !== ACC_W'(60) || out_count !== CNT_W'(3)) begin
            fails++;
            $display("FAIL hold%0d: got rdy/vld=%b sum=%0d cnt=%0d expected 01/60/3",
                     i, {in_ready, out_valid}, out_sum, out_count);
         end
      end
      in_valid  = 1'b0;
      in_last   = 1'b0;
      out_ready = 1'b1;
      tick();
      tests++;
      if ({in_ready, out_valid} !== 2'b10) begin
         fails++;
         $display("FAIL hold_release: got rdy/vld=%b expected 10", {in_ready, out_valid});
      end
      push(64'd7, 1'b1, ok);
      tests++;
      if (out_valid !== 1'b1 || out_sum !== ACC_W'(7) || out_count !== CNT_W'(1)) begin
         fails++;
         $display("FAIL fresh_frame: got vld=%b sum=%0d cnt=%0d expected 1/7/1", out_valid, out_sum, out_count);
      end
      tick();
   endtask

   task automatic test_acc_clear();
      bit ok;
      out_ready = 1'b1;
      push(64'd100, 1'b0, ok);
      push(64'd200, 1'b0, ok);
      in_valid  = 1'b1;
      in_prod   = 64'd300;
      in_last   = 1'b1;
      acc_clear = 1'b1;
      tick();
      acc_clear = 1'b0;
      in_valid  = 1'b0;
      in_last   = 1'b0;
      tests++;
      if ({in_ready, out_valid} !== 2'b10 || out_sum !== ACC_W'(7) || out_count !== CNT_W'(1)) begin
         fails++;
         $display("FAIL clear_abort: got rdy/vld=%b sum=%0d cnt=%0d expected 10/7/1",
                  {in_ready, out_valid}, out_sum, out_count);
      end
      tick();
      tick();
      tests++;
      if (out_valid !== 1'b0) begin
         fails++;
         $display("FAIL clear_quiet: got vld=%b expected 0", out_valid);
      end
      out_ready = 1'b0;
      push(64'd5, 1'b1, ok);
      tests++;
      if (out_valid !== 1'b1 || out_sum !== ACC_W'(5) || out_count !== CNT_W'(1)) begin
         fails++;
         $display("FAIL clear_next: got vld=%b sum=%0d cnt=%0d expected 1/5/1", out_valid, out_sum, out_count);
      end
      acc_clear = 1'b1;
      tick();
      acc_clear = 1'b0;
      tests++;
      if ({in_ready, out_valid} !== 2'b10 || out_sum !== ACC_W'(5)) begin
         fails++;
         $display("FAIL clear_done: got rdy/vld=%b sum=%0d expected 10/5", {in_ready, out_valid}, out_sum);
      end
      out_ready = 1'b1;
      push(64'd9, 1'b1, ok);
      tests++;
      if (out_valid !== 1'b1 || out_sum !== ACC_W'(9) || out_count !== CNT_W'(1)) begin
         fails++;
         $display("FAIL clear_after_done: got vld=%b sum=%0d cnt=%0d expected 1/9/1", out_valid, out_sum, out_count);
      end
      tick();
   endtask

   task automatic test_reset_in_done();
      bit ok;
      out_ready = 1'b0;
      push(64'd3, 1'b1, ok);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      tests++;
      if ({in_ready, out_valid} !== 2'b10 || out_sum !== '0 || out_count !== '0 || out_ovf !== 1'b0) begin
         fails++;
         $display("FAIL reset_done: got rdy/vld=%b sum=%0d cnt=%0d ovf=%b expected 10/0/0/0",
                  {in_ready, out_valid}, out_sum, out_count, out_ovf);
      end
      out_ready = 1'b1;
   endtask

   task automatic test_all_ones();
      bit ok;
      logic [ACC_W-1:0] es;
      logic             eo;
      model(80'd5 * 80'(ONES), es, eo);
      out_ready = 1'b1;
      for (int i = 0; i < 5; i++) push(ONES, (i == 4), ok);
      tests++;
      if (out_valid !== 1'b1 || out_sum !== es || out_ovf !== eo || out_count !== CNT_W'(5)) begin
         fails++;
         $display("FAIL all_ones: got vld=%b sum=%0h ovf=%b cnt=%0d expected 1/%0h/%b/5",
                  out_valid, out_sum, out_ovf, out_count, es, eo);
      end
      tick();
      push(64'd2, 1'b1, ok);
      tests++;
      if (out_sum !== ACC_W'(2) || out_ovf !== 1'b0) begin
         fails++;
         $display("FAIL ovf_restart: got sum=%0h ovf=%b expected 2/0", out_sum, out_ovf);
      end
      tick();
   endtask

   task automatic test_random();
      bit ok;
      int len;
      int c;
      int stall;
      logic [79:0]      t;
      logic [63:0]      p;
      logic [ACC_W-1:0] es;
      logic             eo;
      out_ready = 1'b0;
      t = '0;
      c = 0;
      for (int f = 0; f < 40; f++) begin
         len = $urandom_range(1, 11);
         for (int j = 0; j < len; j++) begin
            case ($urandom_range(0, 3))
               0:       p = ONES;
               1:       p = 64'($urandom_range(0, 1000));
               default: p = {$urandom, $urandom};
            endcase
            repeat ($urandom_range(0, 1)) tick();
            push(p, (j == len - 1), ok);
            tests++;
            if (!ok) begin
               fails++;
               $display("FAIL rand_push_timeout: got in_ready=0 expected 1");
            end
            t = t + 80'(p);
            c++;
            if (j == len - 1 || c == N) begin
               wait_out(ok);
               model(t, es, eo);
               tests++;
               if (!ok || out_sum !== es || out_count !== CNT_W'(c) || out_ovf !== eo) begin
                  fails++;
                  $display("FAIL rand_frame%0d: got vld=%b sum=%0h cnt=%0d ovf=%b expected 1/%0h/%0d/%b",
                           f, out_valid, out_sum, out_count, out_ovf, es, c, eo);
               end
               stall = $urandom_range(0, 3);
               for (int s = 0; s < stall; s++) begin
                  tick();
                  tests++;
                  if (out_valid !== 1'b1 || out_sum !== es) begin
                     fails++;
                     $display("FAIL rand_stall%0d: got vld=%b sum=%0h expected 1/%0h", f, out_valid, out_sum, es);
                  end
               end
               out_ready = 1'b1;
               tick();
               out_ready = 1'b0;
               t = '0;
               c = 0;
            end
         end
      end
      out_ready = 1'b1;
   endtask

   initial begin
      rst       = 1'b0;
      in_valid  = 1'b0;
      in_prod   = '0;
      in_last   = 1'b0;
      acc_clear = 1'b0;
      out_ready = 1'b1;
      test_reset();
      test_full_frame();
      test_carry();
      test_backpressure();
      test_acc_clear();
      test_reset_in_done();
      test_all_ones();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
